// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks register writers in E/M/W, decides D-stage stall and rs/rt forward selects.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_scoreboard #(
    parameter int T_W   = 3,
    parameter int REG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_W-1:0]      id_rs,
    input  logic [REG_W-1:0]      id_rt,
    input  logic signed [T_W-1:0] id_tuse_rs,
    input  logic signed [T_W-1:0] id_tuse_rt,
    input  logic signed [T_W-1:0] id_tnew,
    input  logic                  id_regwrite,
    input  logic [REG_W-1:0]      id_wreg,
    input  logic                  hold,
    output logic                  stall,
    output logic [1:0]            fwd_rs_sel,
    output logic [1:0]            fwd_rt_sel,
    output logic [31:0]           stall_cnt
);

    localparam int TN_W = T_W - 1;
    localparam logic signed [T_W-1:0] ONE_S = T_W'(1);

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] wreg;
        logic [TN_W-1:0]  tnew;
    } entry_t;

    entry_t e_q, m_q, w_q;
    entry_t e_d, m_d, w_d;
    entry_t new_entry;
    entry_t m_adv, w_adv;

    logic                  chk_rs, chk_rt;
    logic [2:0]            res_rs, res_rt;
    logic signed [T_W-1:0] tnew_m1;

    function automatic logic [TN_W-1:0] dec_sat(input logic [TN_W-1:0] t);
        return (t == '0) ? '0 : t - TN_W'(1);
    endfunction

    function automatic logic signed [T_W-1:0] tn_s(input logic [TN_W-1:0] t);
        return signed'({1'b0, t});
    endfunction

    // Returns {stall, sel}; the nearest matching stage shadows older ones.
    function automatic logic [2:0] check_src(
        input logic                  chk,
        input logic [REG_W-1:0]      s,
        input logic signed [T_W-1:0] tuse,
        input entry_t                e,
        input entry_t                m,
        input entry_t                w
    );
        logic       hit_e, hit_m, hit_w, st;
        logic [1:0] sel;
        hit_e = chk && e.v && (e.wreg == s);
        hit_m = chk && m.v && (m.wreg == s);
        hit_w = chk && w.v && (w.wreg == s);
        st = (hit_e && (tn_s(e.tnew) > tuse)) ||
             (hit_m && (tn_s(m.tnew) > tuse)) ||
             (hit_w && (tn_s(w.tnew) > tuse));
        if (hit_e)      sel = (e.tnew == '0) ? 2'd1 : 2'd0;
        else if (hit_m) sel = (m.tnew == '0) ? 2'd2 : 2'd0;
        else if (hit_w) sel = (w.tnew == '0) ? 2'd3 : 2'd0;
        else            sel = 2'd0;
        return {st, sel};
    endfunction

    always_comb begin
        chk_rs = id_valid && !id_tuse_rs[T_W-1] && (id_rs != '0);
        chk_rt = id_valid && !id_tuse_rt[T_W-1] && (id_rt != '0);
        res_rs = check_src(chk_rs, id_rs, id_tuse_rs, e_q, m_q, w_q);
        res_rt = check_src(chk_rt, id_rt, id_tuse_rt, e_q, m_q, w_q);
        stall      = res_rs[2] | res_rt[2];
        fwd_rs_sel = res_rs[1:0];
        fwd_rt_sel = res_rt[1:0];
    end

    always_comb begin
        tnew_m1   = id_tnew - ONE_S;
        new_entry = '0;
        if (id_valid && id_regwrite && (id_wreg != '0) && !id_tnew[T_W-1]) begin
            new_entry.v    = 1'b1;
            new_entry.wreg = id_wreg;
            // Result already due by E: clamp the countdown at zero.
            new_entry.tnew = (id_tnew > ONE_S) ? tnew_m1[TN_W-1:0] : '0;
        end
    end

    always_comb begin
        m_adv      = e_q;
        m_adv.tnew = dec_sat(e_q.tnew);
        w_adv      = m_q;
        w_adv.tnew = dec_sat(m_q.tnew);
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (!hold) begin
            e_d = stall ? '0 : new_entry;
            m_d = m_adv;
            w_d = w_adv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !hold && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic against an age-based model.
module tb_hazard_scoreboard;

    localparam int T_W   = 3;
    localparam int REG_W = 5;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  id_valid = 1'b0;
    logic [REG_W-1:0]      id_rs = '0;
    logic [REG_W-1:0]      id_rt = '0;
    logic signed [T_W-1:0] id_tuse_rs = '0;
    logic signed [T_W-1:0] id_tuse_rt = '0;
    logic signed [T_W-1:0] id_tnew = '0;
    logic                  id_regwrite = 1'b0;
    logic [REG_W-1:0]      id_wreg = '0;
    logic                  hold = 1'b0;
    logic                  stall;
    logic [1:0]            fwd_rs_sel;
    logic [1:0]            fwd_rt_sel;
    logic [31:0]           stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Model: each in-flight writer remembers its D-relative Tnew and how many
    // pipeline advances it has made (1 = E, 2 = M, 3 = W).
    typedef struct {
        int wreg;
        int tnew;
        int age;
    } rec_t;
    rec_t recs[$];
    int   model_cnt = 0;

    hazard_scoreboard #(.T_W(T_W), .REG_W(REG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_tuse_rs (id_tuse_rs),
        .id_tuse_rt (id_tuse_rt),
        .id_tnew    (id_tnew),
        .id_regwrite(id_regwrite),
        .id_wreg    (id_wreg),
        .hold       (hold),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic src_eval(input int s, input int tuse, output bit st, output int sel);
        int best_age;
        int rem;
        st = 1'b0;
        sel = 0;
        best_age = 99;
        if (!id_valid || tuse < 0 || s == 0) return;
        foreach (recs[i]) begin
            if (recs[i].wreg == s) begin
                rem = recs[i].tnew - recs[i].age;
                if (rem < 0) rem = 0;
                if (rem > tuse) st = 1'b1;
                if (recs[i].age < best_age) begin
                    best_age = recs[i].age;
                    sel = (rem == 0) ? recs[i].age : 0;
                end
            end
        end
    endtask

    task automatic model_eval(output bit st, output int sel_rs, output int sel_rt);
        bit st_rs, st_rt;
        src_eval(int'(id_rs), int'(id_tuse_rs), st_rs, sel_rs);
        src_eval(int'(id_rt), int'(id_tuse_rt), st_rt, sel_rt);
        st = st_rs | st_rt;
    endtask

    task automatic drive(input bit v, input int rs, input int rt, input int tuse_rs,
                         input int tuse_rt, input bit rw, input int wreg, input int tnew,
                         input bit h);
        id_valid    = v;
        id_rs       = REG_W'(rs);
        id_rt       = REG_W'(rt);
        id_tuse_rs  = T_W'(tuse_rs);
        id_tuse_rt  = T_W'(tuse_rt);
        id_regwrite = rw;
        id_wreg     = REG_W'(wreg);
        id_tnew     = T_W'(tnew);
        hold        = h;
    endtask

    // One clock: the model advances on the same edge as the DUT; returns at the next negedge.
    task automatic step();
        bit   st;
        int   sr, sq;
        int   tn;
        rec_t nq[$];
        model_eval(st, sr, sq);
        tn = int'(id_tnew);
        @(posedge clk);
        if (rst_n && !hold) begin
            if (st) model_cnt++;
            foreach (recs[i]) begin
                if (recs[i].age + 1 <= 3) nq.push_back('{recs[i].wreg, recs[i].tnew, recs[i].age + 1});
            end
            if (!st && id_valid && id_regwrite && id_wreg != 0 && tn >= 0)
                nq.push_back('{int'(id_wreg), tn, 1});
            recs = nq;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, -1, -1, 0, 0, -1, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, -1, -1, 0, 0, -1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        recs.delete();
        model_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b", {stall, fwd_rs_sel, fwd_rt_sel}, 5'b0);
        end
        vectors++;
        if (stall_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, -1, -1, 1, 1, 3, 0);
        step();
        drive(1, 1, 2, 1, 1, 1, 3, 2, 0);
        #1;
        vectors++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b1_00_00) begin
            miscompares++;
            $display("FAIL load_use_stall: got %b want %b", {stall, fwd_rs_sel, fwd_rt_sel}, 5'b1_00_00);
        end
        step();
        #1;
        vectors++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0_00_00) begin
            miscompares++;
            $display("FAIL load_use_release: got %b want %b", {stall, fwd_rs_sel, fwd_rt_sel}, 5'b0_00_00);
        end
        step();
        idle(4);
    endtask

    task automatic test_alu_branch();
        do_reset();
        drive(1, 0, 0, -1, -1, 1, 2, 2, 0);
        step();
        drive(1, 2, 0, 0, 0, 0, 0, -1, 0);
        #1;
        vectors++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b1_00_00) begin
            miscompares++;
            $display("FAIL alu_branch_stall: got %b want %b", {stall, fwd_rs_sel, fwd_rt_sel}, 5'b1_00_00);
        end
        step();
        #1;
        vectors++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0_10_00) begin
            miscompares++;
            $display("FAIL alu_branch_fwd_m: got %b want %b", {stall, fwd_rs_sel, fwd_rt_sel}, 5'b0_10_00);
        end
        step();
        idle(4);
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive(1, 0, 0, -1, -1, 1, 0, 3, 0);
        step();
        drive(1, 0, 0, 1, 1, 1, 3, 2, 0);
        #1;
        vectors++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0_00_00) begin
            miscompares++;
            $display("FAIL zero_reg: got %b want %b", {stall, fwd_rs_sel, fwd_rt_sel}, 5'b0_00_00);
        end
        step();
        idle(4);
    endtask

    task automatic test_priority();
        do_reset();
        drive(1, 0, 0, -1, -1, 1, 5, 1, 0);
        step();
        drive(1, 0, 0, -1, -1, 1, 5, 1, 0);
        step();
        drive(1, 5, 5, 1, 1, 0, 0, -1, 0);
        #1;
        vectors++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0_01_01) begin
            miscompares++;
            $display("FAIL priority_e_over_m: got %b want %b", {stall, fwd_rs_sel, fwd_rt_sel}, 5'b0_01_01);
        end
        step();
        drive(1, 5, 5, 0, 0, 0, 0, -1, 0);
        #1;
        vectors++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0_10_10) begin
            miscompares++;
            $display("FAIL priority_m_over_w: got %b want %b", {stall, fwd_rs_sel, fwd_rt_sel}, 5'b0_10_10);
        end
        step();
        idle(4);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1, 0, 0, -1, -1, 1, 1, 3, 0);
        step();
        drive(1, 1, 0, 1, -1, 1, 3, 2, 0);
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_stall_pre: got %b want 1", stall);
        end
        rst_n = 1'b0;
        recs.delete();
        model_cnt = 0;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_stall_async: got %b want 0", stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({stall, fwd_rs_sel, fwd_rt_sel} !== 5'b0_00_00) begin
            miscompares++;
            $display("FAIL mid_stall_entries_lost: got %b want %b", {stall, fwd_rs_sel, fwd_rt_sel}, 5'b0);
        end
        step();
        idle(4);
    endtask

    task automatic test_hold();
        do_reset();
        drive(1, 0, 0, -1, -1, 1, 1, 3, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 1, -1, 1, 3, 2, 1);
            #1;
            vectors++;
            if (stall !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_frozen_%0d: got %b want 1", i, stall);
            end
            step();
        end
        drive(1, 1, 0, 1, -1, 1, 3, 2, 0);
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_release_stall: got %b want 1", stall);
        end
        step();
        #1;
        vectors++;
        if ({stall, fwd_rs_sel} !== 3'b0_00) begin
            miscompares++;
            $display("FAIL hold_after_one: got %b want %b", {stall, fwd_rs_sel}, 3'b0);
        end
        vectors++;
        if (stall_cnt !== (STATS ? 32'd1 : 32'd0)) begin
            miscompares++;
            $display("FAIL hold_cnt: got %0d want %0d", stall_cnt, STATS ? 1 : 0);
        end
        step();
        idle(4);
    endtask

    task automatic test_stats();
        do_reset();
        drive(1, 0, 0, -1, -1, 1, 1, 3, 0);
        step();
        drive(1, 1, 2, 1, 1, 1, 3, 2, 1);
        step();
        step();
        drive(1, 1, 2, 1, 1, 1, 3, 2, 0);
        step();
        step();
        drive(1, 0, 0, -1, -1, 1, 4, 3, 0);
        step();
        drive(1, 4, 0, 1, -1, 1, 6, 2, 0);
        step();
        step();
        drive(1, 0, 0, -1, -1, 1, 2, 2, 0);
        step();
        drive(1, 2, 0, 0, 0, 0, 0, -1, 0);
        step();
        step();
        idle(4);
        #1;
        vectors++;
        if (stall_cnt !== (STATS ? 32'd3 : 32'd0)) begin
            miscompares++;
            $display("FAIL stats_three_stalls: got %0d want %0d", stall_cnt, STATS ? 3 : 0);
        end
    endtask

    task automatic test_random();
        bit st;
        int sr, sq;
        logic [31:0] exp_cnt;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 4)) - 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  int'($urandom_range(0, 4)) - 1, $urandom_range(0, 9) == 0);
            #1;
            model_eval(st, sr, sq);
            exp_cnt = STATS ? 32'(model_cnt) : 32'd0;
            vectors++;
            if ({stall, fwd_rs_sel, fwd_rt_sel} !== {st, 2'(sr), 2'(sq)}) begin
                miscompares++;
                $display("FAIL random_%0d: got %b want %b", n, {stall, fwd_rs_sel, fwd_rt_sel},
                         {st, 2'(sr), 2'(sq)});
            end
            vectors++;
            if (stall_cnt !== exp_cnt) begin
                miscompares++;
                $display("FAIL random_cnt_%0d: got %0d want %0d", n, stall_cnt, exp_cnt);
            end
            step();
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_branch();
        test_zero_reg();
        test_priority();
        test_reset_mid_stall();
        test_hold();
        test_stats();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
